// File: rtl/receiver_calc.sv
// receiver_calc: UART 8N1 receiver that assembles CR-terminated calculator messages.
module receiver_calc #(
    parameter int N = 8,
    parameter int M = 128,
    parameter int BIT_TICKS = 10417,
    parameter logic [N-1:0] TERM = 8'h0D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rxd_pin,
    output logic [N-1:0] byte_data,
    output logic         byte_valid,
    output logic [M-1:0] msg,
    output logic [4:0]   msg_len,
    output logic         msg_valid,
    output logic         frame_err,
    output logic [3:0]   led
);
    localparam int SLOTS = M / N;
    localparam int CW = $clog2(BIT_TICKS);
    localparam int BW = $clog2(N);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_nx;
    logic           rx_m, rx_s, rx_q;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  bit_idx;
    logic [N-1:0]   sh;
    logic [M-1:0]   acc;
    logic [4:0]     idx;
    logic           ovf, tgl, receiving;

    wire tick = cnt == CW'(BIT_TICKS - 1);
    wire mid  = cnt == CW'(BIT_TICKS / 2 - 1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // A start edge needs rx_s to have been high the cycle before, so a held break never re-triggers
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (rx_q && !rx_s) state_nx = START;
            START: if (mid) state_nx = rx_s ? IDLE : DATA;
            DATA:  if (tick && bit_idx == BW'(N - 1)) state_nx = STOP;
            STOP:  if (tick) state_nx = IDLE;
        endcase
    end

    always_comb begin
        receiving = state != IDLE;
        led = {tgl, ovf, frame_err, receiving};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rx_m, rx_s, rx_q} <= '1;
            cnt <= '0;
            bit_idx <= '0;
            sh <= '0;
            acc <= '0;
            idx <= '0;
            ovf <= 1'b0;
            tgl <= 1'b0;
            byte_data <= '0;
            byte_valid <= 1'b0;
            msg <= '0;
            msg_len <= '0;
            msg_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m <= rxd_pin;
            rx_s <= rx_m;
            rx_q <= rx_s;
            byte_valid <= 1'b0;
            msg_valid <= 1'b0;
            cnt <= (state == IDLE || (state == START && mid) || tick) ? '0 : cnt + 1'b1;
            if (state == IDLE) bit_idx <= '0;
            if (state == DATA && tick) begin
                sh <= {rx_s, sh[N-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == STOP && tick) begin
                if (rx_s) begin
                    byte_data <= sh;
                    byte_valid <= 1'b1;
                end else frame_err <= 1'b1;
            end
            if (byte_valid) begin
                if (byte_data == TERM) begin
                    msg_valid <= 1'b1;
                    msg <= acc;
                    msg_len <= idx;
                    acc <= '0;
                    idx <= '0;
                    ovf <= 1'b0;
                    frame_err <= 1'b0;
                    tgl <= ~tgl;
                end else if (idx < 5'(SLOTS)) begin
                    for (int i = 0; i < SLOTS; i++)
                        if (idx == 5'(i)) acc[M-1-N*i -: N] <= byte_data;
                    idx <= idx + 1'b1;
                end else ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_receiver_calc.sv
// tb_receiver_calc: randomized bench for receiver_calc against a character-queue message model.
module tb_receiver_calc;
    localparam int BT = 16;

    logic         clk = 1'b0, reset = 1'b0, rxd_pin = 1'b1;
    logic [7:0]   byte_data;
    logic         byte_valid, msg_valid, frame_err;
    logic [127:0] msg;
    logic [4:0]   msg_len;
    logic [3:0]   led;

    receiver_calc #(.N(8), .M(128), .BIT_TICKS(BT), .TERM(8'h0D)) dut (
        .clk(clk), .reset(reset), .rxd_pin(rxd_pin), .byte_data(byte_data),
        .byte_valid(byte_valid), .msg(msg), .msg_len(msg_len), .msg_valid(msg_valid),
        .frame_err(frame_err), .led(led)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0]   exp_bytes[$];
    logic [127:0] exp_msgs[$];
    int           exp_lens[$];
    logic [7:0]   chars[$];
    bit           m_ovf = 0, m_fe = 0, m_tgl = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [127:0] m;
        exp_bytes.push_back(b);
        if (b == 8'h0D) begin
            m = '0;
            foreach (chars[i]) m[127-8*i -: 8] = chars[i];
            exp_msgs.push_back(m);
            exp_lens.push_back(chars.size());
            chars.delete();
            m_ovf = 0;
            m_fe = 0;
            m_tgl = ~m_tgl;
        end else if (chars.size() < 16) chars.push_back(b);
        else m_ovf = 1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_frame_err"}, frame_err, m_fe);
        check({tag, "_led"}, led, {m_tgl, m_ovf, m_fe, 1'b0});
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input int abort_bit = -1);
        rxd_pin = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                reset = 1'b0;
                rxd_pin = 1'b1;
                repeat (5) @(negedge clk);
                reset = 1'b1;
                chars.delete();
                m_ovf = 0;
                m_fe = 0;
                m_tgl = 0;
                repeat (2 * BT) @(negedge clk);
                check_status("abort");
                return;
            end
            rxd_pin = b[i];
            repeat (BT) @(negedge clk);
        end
        if (stop_ok) model_byte(b);
        else m_fe = 1;
        rxd_pin = stop_ok;
        repeat (BT) @(negedge clk);
        rxd_pin = 1'b1;
        repeat ($urandom_range(4, 20)) @(negedge clk);
        check_status("byte");
    endtask

    always @(negedge clk) begin
        if (byte_valid) begin
            if (exp_bytes.size() == 0) check("byte_extra", byte_valid, 1'b0);
            else check("byte", byte_data, exp_bytes.pop_front());
        end
        if (msg_valid) begin
            if (exp_msgs.size() == 0) check("msg_extra", msg_valid, 1'b0);
            else begin
                check("msg", msg, exp_msgs.pop_front());
                check("msg_len", msg_len, exp_lens.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] s[$];
        repeat (5) @(negedge clk);
        check("reset_outputs", {byte_data, byte_valid, msg, msg_len, msg_valid, frame_err, led}, '0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        s = '{8'h31, 8'h32, 8'h2B, 8'h33, 8'h0D};
        foreach (s[i]) send(s[i], 1);
        check("calc_msg_hi", msg[127:96], 32'h31322B33);
        check("calc_msg_lo", msg[95:0], 96'h0);
        check("calc_len", msg_len, 5'd4);
        check("calc_led3", led[3], 1'b1);

        send(8'h0D, 1);
        check("empty_len", msg_len, 5'd0);
        check("empty_msg", msg, 128'h0);

        send(8'h41, 0);
        check("ferr_led1", led[1], 1'b1);
        send(8'h37, 1);
        send(8'h0D, 1);
        check("ferr_clear", frame_err, 1'b0);
        check("ferr_len", msg_len, 5'd1);

        for (int i = 0; i < 18; i++) begin
            send(8'h41, 1);
            if (i == 16) check("ovf_led2", led[2], 1'b1);
        end
        send(8'h0D, 1);
        check("full_msg", msg, {16{8'h41}});
        check("full_len", msg_len, 5'd16);
        check("ovf_clear", led[2], 1'b0);

        rxd_pin = 1'b0;
        repeat (4) @(negedge clk);
        rxd_pin = 1'b1;
        @(negedge clk);
        check("glitch_rx", led[0], 1'b1);
        repeat (BT / 2 + 3) @(negedge clk);
        check("glitch_idle", led[0], 1'b0);

        send(8'h39, 1, 3);
        send(8'h35, 1);
        send(8'h0D, 1);
        check("abort_len", msg_len, 5'd1);
        check("abort_msg_hi", msg[127:120], 8'h35);

        rxd_pin = 1'b0;
        repeat (20 * BT) @(negedge clk);
        m_fe = 1;
        check_status("break");
        rxd_pin = 1'b1;
        repeat (BT) @(negedge clk);
        send(8'h37, 1);
        send(8'h0D, 1);

        repeat (3) begin
            int len = $urandom_range(0, 18);
            for (int i = 0; i < len; i++)
                send(8'($urandom_range(8'h20, 8'h7E)), $urandom_range(0, 9) != 0);
            send(8'h0D, 1);
        end

        repeat (50) @(negedge clk);
        check("bytes_pending", exp_bytes.size(), 0);
        check("msgs_pending", exp_msgs.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
